// File: rtl/event_encoder_pkg.sv
// Shared constants, FSM state encoding and helpers for the 8-to-3 event encoder.
// Build option: EVENT_ENCODER_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package event_encoder_pkg;

    localparam int N_IN   = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    typedef logic [N_IN-1:0]   vec_t;
    typedef logic [CODE_W-1:0] code_t;

    function automatic vec_t code_to_onehot(input code_t c);
        return vec_t'(1) << c;
    endfunction

endpackage

// File: rtl/pri_sel8.sv
// Combinational 8-way selector: fixed priority (highest index wins) or round-robin from base+1.
// Latency: zero (pure combinational). Backpressure: none, stateless. Macro: EVENT_ENCODER_ROUND_ROBIN_EN.
module pri_sel8
    import event_encoder_pkg::*;
(
    input  logic [N_IN-1:0]   req,
    input  logic [CODE_W-1:0] base,
    output logic              any,
    output logic [CODE_W-1:0] idx,
    output logic [N_IN-1:0]   onehot
);

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    logic [CODE_W-1:0] cand;

    // Walk from farthest to nearest so the last hit is the first one after base.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = N_IN; k >= 1; k--) begin
            cand = base + CODE_W'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end
`else
    logic unused_base;
    assign unused_base = ^base;

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (req[k]) begin
                idx = CODE_W'(k);
                any = 1'b1;
            end
        end
    end
`endif

    assign onehot = any ? code_to_onehot(idx) : '0;

endmodule

// File: rtl/event_encoder8to3.sv
// Captures events on 8 lines into a pending register and presents them one index at a time.
// Latency: event in cycle n -> pend in n+1 -> valid/Y in n+2; back-to-back with no bubble.
// Backpressure: ready low holds Y/valid; pend keeps accumulating, repeats while pending set ovf.
// Macro: EVENT_ENCODER_ROUND_ROBIN_EN enables round-robin selection.
module event_encoder8to3
    import event_encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   I,
    input  logic              E,
    output logic [CODE_W-1:0] Y,
    output logic              valid,
    input  logic              ready,
    output logic [N_IN-1:0]   pend,
    output logic              ovf
);

    state_t            state;
    state_t            state_nxt;
    logic [CODE_W-1:0] y_nxt;
    logic [CODE_W-1:0] sel_base;
    logic [CODE_W-1:0] sel_idx;
    logic              sel_any;
    logic              load;
    logic [N_IN-1:0]   sel_onehot;
    logic [N_IN-1:0]   taken;
    logic [N_IN-1:0]   captured;
    logic [N_IN-1:0]   pend_nxt;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    logic [CODE_W-1:0] rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= CODE_W'(N_IN - 1);
        end else if (load) begin
            rr_ptr <= sel_idx;
        end
    end

    assign sel_base = rr_ptr;
`else
    assign sel_base = '0;
`endif

    pri_sel8 u_sel (
        .req    (pend),
        .base   (sel_base),
        .any    (sel_any),
        .idx    (sel_idx),
        .onehot (sel_onehot)
    );

    // A load happens whenever the output slot is free or being emptied this edge.
    always_comb begin
        state_nxt = state;
        y_nxt     = Y;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_any) begin
                    load      = 1'b1;
                    y_nxt     = sel_idx;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    if (sel_any) begin
                        load  = 1'b1;
                        y_nxt = sel_idx;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    assign taken    = load ? sel_onehot : '0;
    assign captured = I & {N_IN{E}};
    assign pend_nxt = (pend & ~taken) | captured;
    assign valid    = (state == ST_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            Y     <= '0;
            pend  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            Y     <= y_nxt;
            pend  <= pend_nxt;
            if (|(captured & pend & ~taken)) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_event_encoder8to3.sv
// Randomized scoreboard bench for event_encoder8to3 against a behavioural pending-set model.
module tb_event_encoder8to3;
    import event_encoder_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] I     = '0;
    logic       E     = 1'b0;
    logic       ready = 1'b0;
    logic [2:0] Y;
    logic       valid;
    logic [7:0] pend;
    logic       ovf;

    int total = 0;
    int bad   = 0;
    int expq[$];

    // Reference model: set of pending lines, an output slot, a sticky overflow flag.
    bit mp[8];
    bit mh;
    int my;
    bit movf;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    int mptr;
`endif

    always #5 clk = ~clk;

    event_encoder8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .I     (I),
        .E     (E),
        .Y     (Y),
        .valid (valid),
        .ready (ready),
        .pend  (pend),
        .ovf   (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 8; j++) mp[j] = 1'b0;
        mh   = 1'b0;
        my   = 0;
        movf = 1'b0;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
        mptr = 7;
`endif
        expq.delete();
    endtask

    task automatic model_cycle(input logic [7:0] iv, input bit ev, input bit rv);
        int sel;
        bit evt;
        sel = -1;
        if (!mh || rv) begin
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
            for (int d = 1; d <= 8; d++)
                if (sel < 0 && mp[(mptr + d) % 8]) sel = (mptr + d) % 8;
`else
            for (int j = 7; j >= 0; j--)
                if (sel < 0 && mp[j]) sel = j;
`endif
        end
        for (int j = 0; j < 8; j++) begin
            evt = iv[j] && ev;
            if (j == sel) begin
                mp[j] = evt;
            end else begin
                if (evt && mp[j]) movf = 1'b1;
                mp[j] = mp[j] || evt;
            end
        end
        if (sel >= 0) begin
            mh = 1'b1;
            my = sel;
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
            mptr = sel;
`endif
            expq.push_back(sel);
        end else if (mh && rv) begin
            mh = 1'b0;
        end
    endtask

    task automatic step(input logic [7:0] iv, input bit ev, input bit rv);
        logic [7:0] mpend;
        I     = iv;
        E     = ev;
        ready = rv;
        model_cycle(iv, ev, rv);
        @(posedge clk);
        #1;
        for (int j = 0; j < 8; j++) mpend[j] = mp[j];
        chk("pend", pend, mpend);
        chk("valid", valid, mh);
        chk("ovf", ovf, movf);
        chk("y", Y, my);
    endtask

    // Monitor: every accepted transfer must match the next index the model presented.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && valid && ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    chk("xfer_y", Y, expq.pop_front());
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pend", pend, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_y", Y, 0);
        rst_n = 1'b1;

        // Single event latency
        step(8'h10, 1'b1, 1'b1);
        chk("single_pend", pend, 8'h10);
        step(8'h00, 1'b1, 1'b1);
        chk("single_valid", valid, 1);
        chk("single_y", Y, 4);
        step(8'h00, 1'b1, 1'b1);
        chk("single_done", valid, 0);
        chk("single_pend0", pend, 0);

        // Simultaneous events
        step(8'h85, 1'b1, 1'b1);
        repeat (5) step(8'h00, 1'b1, 1'b1);

        // Backpressure with a repeat on a pending line
        step(8'h05, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        repeat (4) step(8'h00, 1'b1, 1'b0);
        chk("bp_y", Y, 2);
        chk("bp_valid", valid, 1);
        chk("bp_pend", pend, 8'h01);
        chk("bp_ovf", ovf, 1);
        repeat (4) step(8'h00, 1'b1, 1'b1);

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
        step(8'hFF, 1'b1, 1'b1);
        repeat (9) step(8'h00, 1'b1, 1'b1);
        step(8'h81, 1'b1, 1'b1);
        repeat (4) step(8'h00, 1'b1, 1'b1);
`endif

        // Capture gating
        repeat (3) step(8'hFF, 1'b0, 1'b1);
        chk("gate_pend", pend, 0);
        chk("gate_valid", valid, 0);

        // Reset in the middle of HOLD
        step(8'h30, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", valid, 0);
        chk("midrst_pend", pend, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_y", Y, 0);
        model_reset();
        rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            logic [7:0] iv;
            bit ev;
            bit rv;
            iv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            ev = ($urandom_range(0, 9) != 0);
            rv = ($urandom_range(0, 9) < 7);
            step(iv, ev, rv);
        end

        repeat (20) step(8'h00, 1'b1, 1'b1);
        chk("drain_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
